// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions.
// Holds the opcode constants that decode keys on, the PC increment, the fetch
// FSM state type, and the {pc, word} entry type used by the instruction buffer.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Clears the byte offset so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_req_*     : request channel to instruction memory (valid/ready, address)
//   imem_resp_*    : in-order response channel from instruction memory
//   redirect_*     : single-cycle branch / PC override from downstream
//   instr_*        : instruction handshake toward decode with opcode/funct split
// Modport master is the fetch unit; modport slave is the memory/decode side.
interface instr_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  instr_op;
    logic [5:0]  instr_field;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, instr_op, instr_field,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, instr_op, instr_field,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: small circular buffer of {pc, word} entries for the fetch stage.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i/data   : write one entry (accepted when not full, or when popping)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the buffer; overrides same-cycle push and pop
//   head_o        : oldest entry, valid when !empty_o
//   count_o       : number of stored entries (0..DEPTH)
//   empty_o/full_o: occupancy flags
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_MAX);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i) && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding controlUnit / aluControlUnit.
// Owns the PC, issues in-order word requests to instruction memory under a
// credit limit, buffers returned words in fetch_fifo and hands one instruction
// per handshake to decode. Redirects flush buffered words and discard the
// responses still in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_unit_if.master (imem request/response, redirect,
//                decode handshake with instr/instr_pc/instr_op/instr_field)
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);

    localparam int unsigned   CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic          redirect;
    logic          credit_ok;
    logic          req_valid;
    logic          accept;
    logic          resp_take;
    logic          resp_drop;
    logic          push;
    logic          pop;

    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [31:0]   out_word;
    logic [31:0]   out_pc;

    // ------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------
    always_comb begin
        redirect  = bus.redirect_valid;
        // Buffered words plus outstanding requests never exceed the buffer,
        // so every response that is kept has a free slot waiting for it.
        credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CREDIT_MAX;
        req_valid = (state_q != IDLE) && credit_ok && !redirect;
        accept    = req_valid && bus.imem_req_ready;
        resp_take = bus.imem_resp_valid && (inflight_q != '0);
        resp_drop = resp_take && (drop_cnt_q != '0);
        push      = resp_take && !resp_drop && !redirect && (!fifo_full || pop);
        pop       = !fifo_empty && bus.instr_ready && !redirect;
    end

    // ------------------------------------------------------------------
    // Datapath next state: PC, response tag, in-flight and drop counters
    // ------------------------------------------------------------------
    always_comb begin
        inflight_d = inflight_q;
        if (accept)    inflight_d = inflight_d + CNT_ONE;
        if (resp_take) inflight_d = inflight_d - CNT_ONE;

        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;

        if (redirect) begin
            pc_d       = align_word(bus.redirect_pc);
            // Kept responses restart at the new target once the stale ones
            // (everything still outstanding after this cycle) are dropped.
            resp_pc_d  = align_word(bus.redirect_pc);
            drop_cnt_d = inflight_d;
        end else begin
            if (accept)    pc_d       = pc_q + PC_STEP;
            if (push)      resp_pc_d  = resp_pc_q + PC_STEP;
            if (resp_drop) drop_cnt_d = drop_cnt_q - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (redirect && (inflight_d != '0)) state_d = DRAIN;
            end
            DRAIN: begin
                if (redirect) begin
                    state_d = (inflight_d != '0) ? DRAIN : RUN;
                end else if (drop_cnt_d == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    assign push_entry = '{pc: resp_pc_q, word: bus.imem_resp_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Decode fields read as zero while nothing is buffered.
    assign out_word = fifo_empty ? '0 : head.word;
    assign out_pc   = fifo_empty ? '0 : head.pc;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = !fifo_empty;
    assign bus.instr          = out_word;
    assign bus.instr_pc       = out_pc;
    assign bus.instr_op       = out_word[31:26];
    assign bus.instr_field    = out_word[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// A queue-based memory model answers requests in order after a random latency;
// a stream-level reference (next expected request address, next expected
// decode PC, count of kept-but-unconsumed words) predicts every handshake.
// A second instance with RESET_PC near the top of memory runs with tied-off
// inputs to observe address wrap.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } mreq_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if if0();
    instr_fetch_unit_if if1();

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    instr_fetch_unit #(
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (DEPTH)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    assign if1.imem_req_ready  = 1'b1;
    assign if1.imem_resp_valid = 1'b1;
    assign if1.imem_resp_data  = 32'h0000_0020;
    assign if1.redirect_valid  = 1'b0;
    assign if1.redirect_pc     = 32'h0;
    assign if1.instr_ready     = 1'b1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    int unsigned p_rdy, p_ird, lat_min, lat_max;
    int unsigned redir_mode;
    logic [31:0] redir_tgt;
    bit          redir_fired;
    bit          fixed_en;
    logic [31:0] fixed_word;

    logic [31:0] exp_pc, exp_req;
    int unsigned buffered;
    int unsigned acc_cnt, pop_cnt;
    logic [5:0]  first_op, first_field;
    bit          s_req_valid, s_instr_valid;
    logic [31:0] pop_pcs[$];
    logic [31:0] acc1[$];
    mreq_t       memq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (fixed_en) return fixed_word;
        if (a == 32'h0000_0100) return 32'h8C00_0000;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 unit later,
    // predict what the next rising edge does and update the reference.
    task automatic step();
        logic        rsp, redir, acc, pop;
        logic [31:0] w, tgt;
        mreq_t       e;
        @(negedge clk);
        cyc++;
        rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        if0.imem_resp_valid = rsp;
        if0.imem_resp_data  = rsp ? mem_fn(memq[0].addr) : $urandom();
        if0.imem_req_ready  = ($urandom_range(99) < p_rdy);
        if0.instr_ready     = ($urandom_range(99) < p_ird);
        tgt = redir_tgt;
        case (redir_mode)
            1:       redir = 1'b1;
            2:       redir = rsp && if0.instr_valid;
            3: begin
                redir = ($urandom_range(99) < 4);
                tgt   = $urandom();
            end
            default: redir = 1'b0;
        endcase
        if (redir) begin
            redir_fired = 1'b1;
            if (redir_mode == 2) if0.instr_ready = 1'b1;
            if (redir_mode != 3) redir_mode = 0;
        end
        if0.redirect_valid = redir;
        if0.redirect_pc    = tgt;
        #1;
        acc = if0.imem_req_valid && if0.imem_req_ready;
        pop = if0.instr_valid && if0.instr_ready && !redir;
        s_req_valid   = if0.imem_req_valid;
        s_instr_valid = if0.instr_valid;

        check("instr_valid", if0.instr_valid, buffered > 0);
        if (if0.instr_valid) begin
            w = mem_fn(exp_pc);
            check("instr_pc", if0.instr_pc, exp_pc);
            check("instr", if0.instr, w);
            check("instr_op", if0.instr_op, w[31:26]);
            check("instr_field", if0.instr_field, w[5:0]);
        end
        if (redir) check("no_req_on_redirect", if0.imem_req_valid, 1'b0);
        if (if0.imem_req_valid && !redir) check("req_addr", if0.imem_req_addr, exp_req);
        if (if1.imem_req_valid && acc1.size() < 3) acc1.push_back(if1.imem_req_addr);

        if (rsp) begin
            e = memq.pop_front();
            if (!e.stale && !redir) buffered++;
        end
        if (pop) begin
            if (pop_pcs.size() == 0) begin
                first_op    = if0.instr_op;
                first_field = if0.instr_field;
            end
            pop_pcs.push_back(if0.instr_pc);
            buffered--;
            pop_cnt++;
            exp_pc = exp_pc + 32'd4;
        end
        if (acc) begin
            e.addr  = if0.imem_req_addr;
            e.due   = cyc + $urandom_range(lat_max, lat_min);
            e.stale = 1'b0;
            memq.push_back(e);
            acc_cnt++;
            exp_req = exp_req + 32'd4;
        end
        if (redir) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            buffered = 0;
            exp_pc   = tgt & 32'hFFFF_FFFC;
            exp_req  = tgt & 32'hFFFF_FFFC;
        end
        check("credit_bound", (memq.size() + buffered) <= DEPTH, 1'b1);
    endtask

    // Asserts reset away from any clock edge, checks the outputs clear at
    // once, then releases on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        if0.imem_req_ready  = 1'b0;
        if0.imem_resp_valid = 1'b0;
        if0.imem_resp_data  = '0;
        if0.redirect_valid  = 1'b0;
        if0.redirect_pc     = '0;
        if0.instr_ready     = 1'b0;
        #1;
        check("rst_req_valid", if0.imem_req_valid, 1'b0);
        check("rst_instr_valid", if0.instr_valid, 1'b0);
        check("rst_instr", if0.instr, 32'h0);
        check("rst_instr_pc", if0.instr_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        memq.delete();
        pop_pcs.delete();
        acc1.delete();
        buffered   = 0;
        exp_pc     = 32'h0;
        exp_req    = 32'h0;
        acc_cnt    = 0;
        pop_cnt    = 0;
        redir_mode = 0;
        #1;
        check("release_req_valid", if0.imem_req_valid, 1'b0);
    endtask

    task automatic set_mode(input int unsigned rdy, input int unsigned ird,
                            input int unsigned lmin, input int unsigned lmax);
        p_rdy   = rdy;
        p_ird   = ird;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.imem_req_ready  = 1'b0;
        if0.imem_resp_valid = 1'b0;
        if0.imem_resp_data  = '0;
        if0.redirect_valid  = 1'b0;
        if0.redirect_pc     = '0;
        if0.instr_ready     = 1'b0;
        redir_mode  = 0;
        redir_tgt   = '0;
        redir_fired = 1'b0;
        fixed_en    = 1'b1;
        fixed_word  = 32'h0000_0020;
        set_mode(100, 100, 1, 1);

        // Straight-line fetch of an R-type add; second instance wraps.
        do_reset();
        step();
        check("first_req_valid", s_req_valid, 1'b1);
        repeat (10) step();
        check("add_pops", pop_pcs.size() >= 3, 1'b1);
        if (pop_pcs.size() >= 3) begin
            check("add_pc0", pop_pcs[0], 32'h0);
            check("add_pc1", pop_pcs[1], 32'h4);
            check("add_pc2", pop_pcs[2], 32'h8);
        end
        check("add_op", first_op, 6'b000000);
        check("add_field", first_field, 6'b100000);
        check("wrap_count", acc1.size(), 3);
        if (acc1.size() == 3) begin
            check("wrap_a0", acc1[0], 32'hFFFF_FFF8);
            check("wrap_a1", acc1[1], 32'hFFFF_FFFC);
            check("wrap_a2", acc1[2], 32'h0000_0000);
        end

        // Decode stalled: buffer fills, requests stop, then drains in order.
        fixed_en = 1'b0;
        set_mode(100, 0, 1, 1);
        do_reset();
        repeat (10) step();
        check("stall_accepts", acc_cnt, 2);
        check("stall_req_valid", s_req_valid, 1'b0);
        check("stall_instr_valid", s_instr_valid, 1'b1);
        set_mode(100, 100, 1, 1);
        repeat (4) step();
        check("stall_pops", pop_pcs.size() >= 2, 1'b1);
        if (pop_pcs.size() >= 2) begin
            check("stall_pc0", pop_pcs[0], 32'h0);
            check("stall_pc1", pop_pcs[1], 32'h4);
        end

        // Redirect to an unaligned target with two requests outstanding.
        set_mode(100, 100, 3, 3);
        do_reset();
        for (int i = 0; i < 10 && memq.size() < 2; i++) step();
        check("redir_inflight", memq.size(), 2);
        redir_tgt  = 32'h0000_0103;
        redir_mode = 1;
        step();
        pop_pcs.delete();
        for (int i = 0; i < 30 && pop_pcs.size() == 0; i++) step();
        check("redir_popped", pop_pcs.size() > 0, 1'b1);
        if (pop_pcs.size() > 0) begin
            check("redir_pc", pop_pcs[0], 32'h0000_0100);
            check("redir_op", first_op, 6'b100011);
        end

        // Redirect coinciding with a response and a pop.
        set_mode(100, 100, 1, 1);
        do_reset();
        repeat (6) step();
        redir_fired = 1'b0;
        redir_tgt   = 32'h0000_2002;
        redir_mode  = 2;
        for (int i = 0; i < 20 && !redir_fired; i++) step();
        check("coincident_redirect", redir_fired, 1'b1);
        redir_mode = 0;
        pop_pcs.delete();
        step();
        check("flushed_after_redirect", s_instr_valid, 1'b0);
        repeat (12) step();
        check("coincident_pops", pop_pcs.size() > 0, 1'b1);
        if (pop_pcs.size() > 0) check("coincident_pc", pop_pcs[0], 32'h0000_2000);

        // Randomised traffic with random redirects and stalls.
        set_mode(70, 60, 1, 4);
        do_reset();
        redir_mode = 3;
        repeat (3000) step();
        redir_mode = 0;
        check("random_progress", pop_cnt > 100, 1'b1);

        // Reset with two requests outstanding, then restart from RESET_PC.
        set_mode(100, 100, 3, 3);
        do_reset();
        for (int i = 0; i < 10 && memq.size() < 2; i++) step();
        check("rst_inflight", memq.size(), 2);
        do_reset();
        step();
        check("restart_req_valid", s_req_valid, 1'b1);
        check("restart_addr", if0.imem_req_addr, 32'h0);
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
